// File: rtl/cpu19_pkg.sv
// Shared definitions for the cpu19 core: datapath width and the load/store
// unit state encoding.
package cpu19_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = LSU_IDLE,
        ST_REQ  = LSU_REQ,
        ST_DONE = LSU_DONE
    } lsu_state_e;

endpackage

// File: rtl/lsu_timeout_counter.sv
// Wait counter for the load/store unit: cleared at issue, counts request
// cycles, and flags the request cycle that exhausts the timeout budget.
module lsu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic inc_in,
    output logic expired_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // NOTE: every variable gets its default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear_in) begin
            count_d = '0;
        end else if (inc_in) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count holds the number of completed request cycles, so the T-th
    // request cycle is the one that sees LAST.
    assign expired_out = inc_in && (count_q == LAST);

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one req/ack transaction per load or store,
// stalls the pipeline meanwhile, and aborts with a sticky error on timeout.
module load_store_unit #(
    parameter int DATA_W         = cpu19_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              ls_valid_in,
    input  logic              ls_wr_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] st_data_in,
    output logic              stall_out,
    output logic              ls_done_out,
    output logic [DATA_W-1:0] ld_data_out,
    output logic              err_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [DATA_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic              mem_ack_in,
    input  logic [DATA_W-1:0] mem_rdata_in
);

    import cpu19_pkg::*;

    lsu_state_e        state_d,     state_q;
    logic              mem_we_d,    mem_we_q;
    logic [DATA_W-1:0] mem_addr_d,  mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
    logic [DATA_W-1:0] ld_data_d,   ld_data_q;
    logic              err_d,       err_q;

    logic cnt_clear;
    logic cnt_inc;
    logic cnt_expired;

    lsu_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (cnt_clear),
        .inc_in     (cnt_inc),
        .expired_out(cnt_expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_data_d   = ld_data_q;
        err_d       = err_q;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ls_valid_in) begin
                    mem_we_d    = ls_wr_in;
                    mem_addr_d  = addr_in;
                    mem_wdata_d = st_data_in;
                    cnt_clear   = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_inc = 1'b1;
                // Ack is tested first so a last-cycle ack beats the timeout.
                if (mem_ack_in) begin
                    if (!mem_we_q) ld_data_d = mem_rdata_in;
                    state_d = ST_DONE;
                end else if (cnt_expired) begin
                    if (!mem_we_q) ld_data_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            // DONE never looks at ls_valid_in: it still shows the op just finished.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_data_q   <= ld_data_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_out   = (state_q == ST_REQ);
    assign ls_done_out   = (state_q == ST_DONE);
    assign stall_out     = ((state_q == ST_IDLE) && ls_valid_in) || (state_q == ST_REQ);
    assign mem_we_out    = mem_we_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;
    assign ld_data_out   = ld_data_q;
    assign err_out       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and random ops against
// a transaction-level model of latency, load data and the sticky error.
module tb_load_store_unit;

    localparam int W = 16;
    localparam int T = 15;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         ls_valid_in;
    logic         ls_wr_in;
    logic [W-1:0] addr_in;
    logic [W-1:0] st_data_in;
    logic         stall_out;
    logic         ls_done_out;
    logic [W-1:0] ld_data_out;
    logic         err_out;
    logic         mem_req_out;
    logic         mem_we_out;
    logic [W-1:0] mem_addr_out;
    logic [W-1:0] mem_wdata_out;
    logic         mem_ack_in;
    logic [W-1:0] mem_rdata_in;

    int errors = 0;
    int checks = 0;

    // Model state: last completed load value and sticky error.
    logic [W-1:0] ld_m;
    logic         err_m;

    load_store_unit #(.DATA_W(W), .TIMEOUT_CYCLES(T)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .ls_valid_in  (ls_valid_in),
        .ls_wr_in     (ls_wr_in),
        .addr_in      (addr_in),
        .st_data_in   (st_data_in),
        .stall_out    (stall_out),
        .ls_done_out  (ls_done_out),
        .ld_data_out  (ld_data_out),
        .err_out      (err_out),
        .mem_req_out  (mem_req_out),
        .mem_we_out   (mem_we_out),
        .mem_addr_out (mem_addr_out),
        .mem_wdata_out(mem_wdata_out),
        .mem_ack_in   (mem_ack_in),
        .mem_rdata_in (mem_rdata_in)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One op issued at a falling edge in IDLE; ack_k is the request cycle
    // carrying the ack (0 or >T means never). Returns at the DONE cycle with
    // ls_valid_in still high.
    task automatic run_op(input bit wr, input logic [W-1:0] a, input logic [W-1:0] d,
                          input int ack_k, input logic [W-1:0] rd);
        bit acked;
        int eff;
        int req_cnt;
        bit done_seen;
        acked = (ack_k >= 1) && (ack_k <= T);
        eff   = acked ? ack_k : T;

        @(negedge clk_in);
        ls_valid_in  = 1'b1;
        ls_wr_in     = wr;
        addr_in      = a;
        st_data_in   = d;
        mem_ack_in   = 1'($urandom_range(0, 1));
        mem_rdata_in = 16'($urandom);
        #1;
        check("issue_stall", 32'(stall_out), 1);
        check("issue_req",   32'(mem_req_out), 0);
        check("issue_done",  32'(ls_done_out), 0);

        req_cnt   = 0;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < T + 4 && !done_seen; cyc++) begin
            @(negedge clk_in);
            mem_ack_in   = 1'b0;
            mem_rdata_in = 16'($urandom);
            if (mem_req_out) begin
                req_cnt++;
                check("req_stall", 32'(stall_out), 1);
                check("req_we",    32'(mem_we_out), 32'(wr));
                check("req_addr",  32'(mem_addr_out), 32'(a));
                check("req_wdata", 32'(mem_wdata_out), 32'(d));
                if (req_cnt == ack_k) begin
                    mem_ack_in   = 1'b1;
                    mem_rdata_in = rd;
                end
            end else if (ls_done_out) begin
                done_seen = 1'b1;
            end else begin
                break;
            end
        end
        mem_ack_in = 1'b0;

        if (!wr) ld_m = acked ? rd : '0;
        if (!acked) err_m = 1'b1;

        check("done_seen",  32'(done_seen), 1);
        check("req_cycles", 32'(req_cnt), 32'(eff));
        check("done_stall", 32'(stall_out), 0);
        check("done_req",   32'(mem_req_out), 0);
        check("ld_data",    32'(ld_data_out), 32'(ld_m));
        check("err",        32'(err_out), 32'(err_m));
    endtask

    task automatic idle_cycle();
        @(negedge clk_in);
        ls_valid_in = 1'b0;
        mem_ack_in  = 1'($urandom_range(0, 1));
        #1;
        check("idle_req",   32'(mem_req_out), 0);
        check("idle_done",  32'(ls_done_out), 0);
        check("idle_stall", 32'(stall_out), 0);
    endtask

    initial begin
        rst_in       = 1'b0;
        ls_valid_in  = 1'b0;
        ls_wr_in     = 1'b0;
        addr_in      = '0;
        st_data_in   = '0;
        mem_ack_in   = 1'b0;
        mem_rdata_in = '0;
        ld_m         = '0;
        err_m        = 1'b0;

        // Reset state, with stall following ls_valid_in combinationally.
        repeat (2) @(negedge clk_in);
        check("rst_req",   32'(mem_req_out), 0);
        check("rst_done",  32'(ls_done_out), 0);
        check("rst_we",    32'(mem_we_out), 0);
        check("rst_addr",  32'(mem_addr_out), 0);
        check("rst_wdata", 32'(mem_wdata_out), 0);
        check("rst_ld",    32'(ld_data_out), 0);
        check("rst_err",   32'(err_out), 0);
        check("rst_stall0", 32'(stall_out), 0);
        ls_valid_in = 1'b1;
        #1;
        check("rst_stall1", 32'(stall_out), 1);
        ls_valid_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        idle_cycle();

        // Load with ack in the first request cycle.
        run_op(1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF);
        idle_cycle();
        // Store acked after 4 request cycles; load data must not move.
        run_op(1'b1, 16'h0012, 16'h1234, 4, 16'h5555);
        idle_cycle();
        // Ack in the final allowed cycle beats the timeout.
        run_op(1'b0, 16'h0099, 16'h0000, T, 16'h00A5);
        idle_cycle();
        // Back-to-back loads with ls_valid_in held through DONE.
        run_op(1'b0, 16'h0100, 16'h0000, 2, 16'h1111);
        run_op(1'b0, 16'h0101, 16'h0000, 3, 16'h2222);
        run_op(1'b1, 16'h0102, 16'hCAFE, 1, 16'h3333);
        idle_cycle();
        // Timeout on a load, then good ops with the error staying set.
        run_op(1'b0, 16'h0200, 16'h0000, 0, 16'h7777);
        idle_cycle();
        run_op(1'b1, 16'h0201, 16'hAAAA, 1, 16'h0000);
        run_op(1'b0, 16'h0202, 16'h0000, 5, 16'h4242);
        idle_cycle();

        // Random ops, including store timeouts and random gaps.
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, T + 2)), 16'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        // Reset asserted in the middle of a request.
        @(negedge clk_in);
        ls_valid_in = 1'b1;
        ls_wr_in    = 1'b0;
        addr_in     = 16'h0777;
        st_data_in  = 16'h0000;
        mem_ack_in  = 1'b0;
        repeat (3) @(negedge clk_in);
        check("mid_req", 32'(mem_req_out), 1);
        #2 rst_in = 1'b0;
        #1;
        ld_m  = '0;
        err_m = 1'b0;
        check("arst_req",   32'(mem_req_out), 0);
        check("arst_done",  32'(ls_done_out), 0);
        check("arst_we",    32'(mem_we_out), 0);
        check("arst_addr",  32'(mem_addr_out), 0);
        check("arst_wdata", 32'(mem_wdata_out), 0);
        check("arst_ld",    32'(ld_data_out), 32'(ld_m));
        check("arst_err",   32'(err_out), 32'(err_m));
        check("arst_stall", 32'(stall_out), 1);
        @(negedge clk_in);
        ls_valid_in = 1'b0;
        rst_in      = 1'b1;
        idle_cycle();
        idle_cycle();
        run_op(1'b0, 16'h0300, 16'h0000, 2, 16'h0F0F);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
